fir_mac_sequencer: RTL

- Controller that runs an 8-tap systolic FIR step on one shared sequential multiplier and one accumulator.
- Holds the sample delay line and walks the coefficient index.
- Drives the multiplier's start/busy handshake deterministically, replacing free-running count-based start pulses.
- Sits between the non-uniform sample source and the coefficient ROM/multiplier pair; emits one filtered word per accepted sample.

---
 rtl/fir_mac_sequencer_if.sv | 34 +++
 rtl/fir_mac_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Handshake and datapath bundle between the FIR MAC sequencer and its
// sample source, coefficient ROM, shared multiplier and result sink.
interface fir_mac_sequencer_if #(
  parameter int WORDLENGTH = 16,
  parameter int IDXW       = 3
);
  logic [WORDLENGTH-1:0] in_word;
  logic                  in_valid;
  logic                  in_ready;
  logic [IDXW-1:0]       coeff_idx;
  logic [WORDLENGTH-1:0] coeff_word;
  logic [WORDLENGTH-1:0] mult_a;
  logic [WORDLENGTH-1:0] mult_b;
  logic                  mult_start;
  logic                  mult_busy;
  logic [WORDLENGTH-1:0] mult_product;
  logic [WORDLENGTH-1:0] out_word;
  logic                  out_valid;
  logic                  timeout_err;

  // Sequencer side: drives ROM address, multiplier operands and results.
  modport master (
    input  in_word, in_valid, coeff_word, mult_busy, mult_product,
    output in_ready, coeff_idx, mult_a, mult_b, mult_start,
           out_word, out_valid, timeout_err
  );

  // Environment side: sample source, ROM, multiplier and result sink.
  modport slave (
    output in_word, in_valid, coeff_word, mult_busy, mult_product,
    input  in_ready, coeff_idx, mult_a, mult_b, mult_start,
           out_word, out_valid, timeout_err
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// 8-tap FIR step sequencer: one shared start/busy multiplier, one wrapping
// accumulator, a sample delay line and a busy watchdog.
module fir_mac_sequencer #(
  parameter int WORDLENGTH = 16,
  parameter int TAPS       = 8,
  parameter int IDXW       = 3,
  parameter int TIMEOUT    = 64
) (
  input logic                 clk30x,
  input logic                 reset,
  fir_mac_sequencer_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

  state_t                state, state_next;
  logic [WORDLENGTH-1:0] x [TAPS];
  logic [WORDLENGTH-1:0] acc;
  logic [WORDLENGTH-1:0] mult_a, mult_b, out_word;
  logic [IDXW-1:0]       k;
  logic [WDW-1:0]        watchdog;
  logic                  mult_start, out_valid, timeout_err;
  logic                  ready, last_tap, wd_expire;

  assign last_tap  = (k == IDXW'(TAPS - 1));
  // The abort fires on the busy cycle whose increment would bring the
  // watchdog to TIMEOUT-1, so the flag lands TIMEOUT cycles after ARM entry.
  assign wd_expire = (watchdog == WDW'(TIMEOUT - 2));

  assign bus.in_ready    = ready;
  assign bus.coeff_idx   = k;
  assign bus.mult_a      = mult_a;
  assign bus.mult_b      = mult_b;
  assign bus.mult_start  = mult_start;
  assign bus.out_word    = out_word;
  assign bus.out_valid   = out_valid;
  assign bus.timeout_err = timeout_err;

  // State register.
  always_ff @(posedge clk30x or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and sample-accept handshake.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = ISSUE;
      end
      ISSUE: state_next = ARM;
      ARM:   state_next = WAIT;
      WAIT: begin
        if (!bus.mult_busy)  state_next = last_tap ? DONE : ISSUE;
        else if (wd_expire)  state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delay line, tap index, operand registers, accumulator, watchdog, outputs.
  always_ff @(posedge clk30x or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < TAPS; i++) x[i] <= '0;
      acc         <= '0;
      k           <= '0;
      watchdog    <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      mult_start  <= 1'b0;
      out_word    <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      out_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x[0] <= bus.in_word;
            for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        ISSUE: begin
          mult_a     <= x[k];
          mult_b     <= bus.coeff_word;
          mult_start <= 1'b1;
        end
        ARM: watchdog <= '0;
        WAIT: begin
          if (!bus.mult_busy) begin
            acc <= acc + bus.mult_product;
            if (!last_tap) k <= k + 1'b1;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE: begin
          out_word  <= acc;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
